// File: rtl/pow_seq_if.sv
// Operand/result bundle for the pow_seq exponentiator: start/busy/done handshake plus data.
interface pow_seq_if #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned EXP_W = 7,
    parameter int unsigned OUT_W = 14
) ();
    logic             start;
    logic [IN_W-1:0]  a;
    logic [EXP_W-1:0] b;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] result;
    logic             overflow;

    modport master (output start, a, b, input busy, done, result, overflow);
    modport slave  (input start, a, b, output busy, done, result, overflow);
endinterface

// File: rtl/pow_seq.sv
// Sequential a^b by LSB-first square-and-multiply, one exponent bit per clock,
// saturating to all-ones when the true result does not fit in OUT_W bits.
module pow_seq #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned EXP_W = 7,
    parameter int unsigned OUT_W = 14
) (
    input  logic        clk,
    input  logic        rst,
    pow_seq_if.slave    bus
);
    localparam int unsigned PROD_W = 2 * OUT_W;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state, state_nxt;
    logic [OUT_W-1:0] acc, acc_nxt;
    logic [OUT_W-1:0] base, base_nxt;
    logic [EXP_W-1:0] e, e_nxt;
    logic             base_ovf, base_ovf_nxt;
    logic             acc_ovf, acc_ovf_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [OUT_W-1:0] result_q, result_nxt;
    logic             ovf_q, ovf_nxt;
    logic [IN_W-1:0]  a_in;
    logic [PROD_W-1:0] p, q;

    assign a_in = bus.a;
    assign p    = PROD_W'(acc) * PROD_W'(base);
    assign q    = PROD_W'(base) * PROD_W'(base);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            base     <= '0;
            e        <= '0;
            base_ovf <= 1'b0;
            acc_ovf  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            base     <= base_nxt;
            e        <= e_nxt;
            base_ovf <= base_ovf_nxt;
            acc_ovf  <= acc_ovf_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            result_q <= result_nxt;
            ovf_q    <= ovf_nxt;
        end
    end

    // Next-state and datapath update; done defaults low so it only ever pulses.
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        base_nxt     = base;
        e_nxt        = e;
        base_ovf_nxt = base_ovf;
        acc_ovf_nxt  = acc_ovf;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        result_nxt   = result_q;
        ovf_nxt      = ovf_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt      = OUT_W'(1);
                    base_nxt     = OUT_W'(a_in);
                    e_nxt        = bus.b;
                    base_ovf_nxt = 1'b0;
                    acc_ovf_nxt  = 1'b0;
                    busy_nxt     = 1'b1;
                    state_nxt    = CALC;
                end
            end
            CALC: begin
                if (e != '0) begin
                    // An overflowed base only poisons acc when it is multiplied in.
                    if (e[0]) begin
                        acc_nxt = p[OUT_W-1:0];
                        if ((p[PROD_W-1:OUT_W] != '0) || base_ovf) begin
                            acc_ovf_nxt = 1'b1;
                        end
                    end
                    base_nxt = q[OUT_W-1:0];
                    if (q[PROD_W-1:OUT_W] != '0) begin
                        base_ovf_nxt = 1'b1;
                    end
                    e_nxt = e >> 1;
                end else begin
                    result_nxt = acc_ovf ? '1 : acc;
                    ovf_nxt    = acc_ovf;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_pow_seq.sv
// Scoreboard bench for pow_seq: driver queues expected results from an
// arithmetic model, monitor checks each done pulse, latency and result hold.
module tb_pow_seq;
    localparam int unsigned IN_W  = 7;
    localparam int unsigned EXP_W = 7;
    localparam int unsigned OUT_W = 14;
    localparam longint unsigned MAXV = (64'd1 << OUT_W) - 64'd1;

    typedef struct {
        logic [OUT_W-1:0] res;
        bit               ovf;
        int               due;
        int unsigned      a;
        int unsigned      b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [OUT_W-1:0] held_r = '0;
    logic             held_o = 1'b0;

    pow_seq_if #(.IN_W(IN_W), .EXP_W(EXP_W), .OUT_W(OUT_W)) bus ();

    pow_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // True a^b with plain integer arithmetic, saturated when it exceeds OUT_W bits.
    function automatic exp_t model(input int unsigned ai, input int unsigned bi, input int acc_cyc);
        exp_t           r;
        longint unsigned v = 1;
        int             len = 0;
        int unsigned    t = bi;
        r.ovf = 1'b0;
        for (int unsigned i = 0; i < bi; i++) begin
            v = v * longint'(ai);
            if (v > MAXV) begin
                r.ovf = 1'b1;
                break;
            end
        end
        r.res = r.ovf ? '1 : OUT_W'(v);
        while (t != 0) begin
            len++;
            t = t >> 1;
        end
        r.due = acc_cyc + len + 1;
        r.a   = ai;
        r.b   = bi;
        return r;
    endfunction

    // Waits (bounded) for idle at a negedge, then issues one operation.
    task automatic issue(input int unsigned ai, input int unsigned bi);
        int n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            vectors++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", bus.busy, n);
            return;
        end
        bus.start = 1'b1;
        bus.a     = IN_W'(ai);
        bus.b     = EXP_W'(bi);
        @(posedge clk);
        #1;
        sb.push_back(model(ai, bi, cyc));
        check("busy_after_start", 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = IN_W'($urandom);
        bus.b     = EXP_W'($urandom);
    endtask

    // Monitor: every cycle either a reset state, a scored done, or a held result.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_done", 64'(bus.done), 64'd0);
            check("rst_result", 64'(bus.result), 64'd0);
            check("rst_overflow", 64'(bus.overflow), 64'd0);
            held_r = '0;
            held_o = 1'b0;
        end else if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_done: result 0x%0h with no operation pending", bus.result);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check($sformatf("result a=%0d b=%0d", x.a, x.b), 64'(bus.result), 64'(x.res));
                check($sformatf("overflow a=%0d b=%0d", x.a, x.b), 64'(bus.overflow), 64'(x.ovf));
                check($sformatf("latency a=%0d b=%0d", x.a, x.b), 64'(cyc), 64'(x.due));
                check("busy_at_done", 64'(bus.busy), 64'd0);
                held_r = x.res;
                held_o = x.ovf;
            end
        end else begin
            check("result_hold", 64'(bus.result), 64'(held_r));
            check("overflow_hold", 64'(bus.overflow), 64'(held_o));
        end
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(3, 4);
        issue(2, 13);
        issue(2, 14);
        issue(127, 2);
        issue(127, 3);
        issue(0, 0);
        issue(5, 0);
        issue(0, 9);
        issue(1, 127);

        // Reset on the third busy cycle discards the operation.
        issue(3, 100);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        issue(3, 2);

        // Start while busy is ignored; operands wiggle mid-run.
        issue(3, 4);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = IN_W'(2);
        bus.b     = EXP_W'(2);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) begin
            bus.a = IN_W'($urandom);
            bus.b = EXP_W'($urandom);
            @(negedge clk);
        end
        // Back-to-back: accepted in the done cycle of the previous operation.
        issue(5, 3);

        for (int i = 0; i < 80; i++) begin
            int unsigned ra, rb;
            case ($urandom_range(0, 3))
                0: begin ra = $urandom_range(0, 3);   rb = $urandom_range(0, 127); end
                1: begin ra = $urandom_range(0, 127); rb = $urandom_range(0, 4);   end
                2: begin ra = $urandom_range(2, 12);  rb = $urandom_range(0, 15);  end
                default: begin ra = $urandom_range(0, 127); rb = $urandom_range(0, 127); end
            endcase
            issue(ra, rb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain: %0d operations never completed", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pow_seq.md
Name: pow_seq

Overview:
- Parametrised sequential exponentiator. Computes result = a^b by LSB-first binary square-and-multiply, one exponent bit per clock.
- Sits in the calculator datapath as the power operator. It replaces the linear repeated-multiply unit.
- Adds a start/busy/done handshake, configurable widths, logarithmic latency and overflow detection with saturation.

Parameters:
- IN_W, 7, width of base operand a; must satisfy IN_W <= OUT_W
- EXP_W, 7, width of exponent operand b
- OUT_W, 14, width of result and of internal accumulator/base registers

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; accepted only when busy=0
- a  input  IN_W  base, unsigned; sampled only on the accepting edge
- b  input  EXP_W  exponent, unsigned; sampled only on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result/overflow are valid
- result  output  OUT_W  a^b, or all-ones on overflow; held until the next done
- overflow  output  1  true result exceeded OUT_W bits; held with result

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, busy=0, done=0, result=0, overflow=0, internal registers cleared. rst has priority over everything, including mid-operation; the in-flight operation is discarded with no done.
- States: IDLE, CALC.
- IDLE, start=1 at an edge:
  - acc<=1, base<=zero-extended a, e<=b, base_ovf<=0, acc_ovf<=0
  - busy<=1, state<=CALC
- IDLE, start=0: hold.
- CALC, e!=0, per edge:
  - if e[0]: p = acc*base at 2*OUT_W bits; acc<=p[OUT_W-1:0]; acc_ovf<=1 if p[2*OUT_W-1:OUT_W]!=0 or base_ovf=1
  - q = base*base at 2*OUT_W bits; base<=q[OUT_W-1:0]; base_ovf<=1 (sticky) if q upper half !=0
  - e<=e>>1
- CALC, e==0, at edge:
  - result<=acc_ovf ? all-ones : acc; overflow<=acc_ovf
  - done<=1, busy<=0, state<=IDLE
- done is forced to 0 on every edge where it is not being set.
- Latency: with L = bit length of b (L=0 for b=0), done is high after exactly L+1 edges following the accepting edge. Worst case is EXP_W+1.
- base_ovf alone never sets overflow. Squaring after the last set bit is harmless; an overflowed base only matters if multiplied into acc.
- Sticky acc_ovf: once set, stays set for the operation.
- 0^0=1, x^0=1, 0^b=0 for b>0, 1^b=1; none of these flag overflow.
- start while busy=1: ignored, operands not resampled.
- start in the cycle done=1 (busy=0): accepted. The new operation begins, and result/overflow keep the old values until the new done.
- a and b may change freely while busy; this has no effect.

Test Plan:
- rst, then a=3, b=4, start pulse: busy=1; done after 4 edges (L=3); result=81, overflow=0, busy=0.
- a=2, b=13: result=8192, overflow=0, done after 5 edges. Base squaring overflows after the final bit, but the flag must stay 0.
- a=2, b=14: overflow=1, result=0x3FFF. a=127, b=2: result=16129, overflow=0. a=127, b=3: overflow=1, result=0x3FFF.
- a=0, b=0 and a=5, b=0: result=1, done after 1 edge. a=0, b=9: result=0, overflow=0. a=1, b=127: result=1, done after 8 edges.
- Start a=3, b=4; pulse start with a=2, b=2 on the second busy cycle; change a/b mid-run: result=81 only, a single done, no second operation.
- Start a=3, b=100; assert rst on the third busy cycle: next edge busy=0, done=0, result=0, overflow=0, no done afterwards. Then a=3, b=2 gives result=9.
- Back-to-back: start asserted in the done cycle with a=5, b=3. Result stays 81 until the new done, then becomes 125.
